// File: rtl/centroid_marker_if.sv
// Pixel stream bus for the centroid crosshair overlay: scan-order pixels in,
// the same stream one cycle later with the marker drawn over it.
interface centroid_marker_if;
  logic [17:0] pixel_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [9:0]  xCenter;
  logic [9:0]  yCenter;
  logic [1:0]  colorSelect;
  logic [17:0] pixel_out;
  logic [9:0]  x_out;
  logic [9:0]  y_out;
  logic        marker_on;

  modport master (
    output pixel_in, x, y, xCenter, yCenter, colorSelect,
    input  pixel_out, x_out, y_out, marker_on
  );

  modport slave (
    input  pixel_in, x, y, xCenter, yCenter, colorSelect,
    output pixel_out, x_out, y_out, marker_on
  );
endinterface

// File: rtl/centroid_marker.sv
// Draws a crosshair at the smoothed centroid of the tracked hue; blinks the
// marker when the reported centroid has stopped moving for a while.
module centroid_marker #(
  parameter int ARM          = 8,
  parameter int STALE_FRAMES = 15,
  parameter int BLINK_LOG2   = 4
) (
  input logic clk,
  input logic reset,
  centroid_marker_if.slave bus
);

  localparam logic signed [10:0] ARM_S     = 11'(ARM);
  localparam logic [7:0]         STALE_MAX = 8'(STALE_FRAMES);

  logic [9:0]          cx;
  logic [9:0]          cy;
  logic [9:0]          prevX;
  logic [9:0]          prevY;
  logic                seeded;
  logic [7:0]          stale;
  logic [BLINK_LOG2:0] frameCnt;

  logic                frameStart;
  logic [10:0]         sumX;
  logic [10:0]         sumY;
  logic signed [10:0]  dx;
  logic signed [10:0]  dy;
  logic                hit;
  logic                suppress;
  logic                drawMarker;

  function automatic logic signed [10:0] diff11(input logic [9:0] a, input logic [9:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic withinArm(input logic signed [10:0] d);
    return (d <= ARM_S) && (d >= -ARM_S);
  endfunction

  function automatic logic [17:0] markerColor(input logic [1:0] sel);
    case (sel)
      2'd0:    return 18'h00FFF;
      2'd1:    return 18'h3F03F;
      default: return 18'h3FFC0;
    endcase
  endfunction

  assign frameStart = (bus.x == 10'd0) && (bus.y == 10'd0);
  assign sumX       = {1'b0, cx} + {1'b0, bus.xCenter};
  assign sumY       = {1'b0, cy} + {1'b0, bus.yCenter};

  // Distances are taken in 11-bit signed so the arms clip at the screen edges.
  assign dx  = diff11(bus.x, cx);
  assign dy  = diff11(bus.y, cy);
  assign hit = ((bus.y == cy) && withinArm(dx)) || ((bus.x == cx) && withinArm(dy));

  assign suppress   = !seeded
                   || ((cx == 10'd0) && (cy == 10'd0))
                   || ((stale == STALE_MAX) && frameCnt[BLINK_LOG2]);
  assign drawMarker = hit && !suppress;

  // Per-frame tracking state, updated on the (0,0) pixel after it has been drawn
  always_ff @(posedge clk) begin
    if (reset) begin
      cx       <= '0;
      cy       <= '0;
      prevX    <= '0;
      prevY    <= '0;
      seeded   <= 1'b0;
      stale    <= '0;
      frameCnt <= '0;
    end else if (frameStart) begin
      if (!seeded) begin
        cx     <= bus.xCenter;
        cy     <= bus.yCenter;
        seeded <= 1'b1;
      end else begin
        cx <= sumX[10:1];
        cy <= sumY[10:1];
      end
      if ((bus.xCenter == prevX) && (bus.yCenter == prevY)) begin
        if (stale != STALE_MAX) stale <= stale + 8'd1;
      end else begin
        stale <= '0;
      end
      prevX    <= bus.xCenter;
      prevY    <= bus.yCenter;
      frameCnt <= frameCnt + 1'b1;
    end
  end

  // Output stage: one cycle from pixel_in to pixel_out
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pixel_out <= '0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.marker_on <= 1'b0;
    end else begin
      bus.pixel_out <= drawMarker ? markerColor(bus.colorSelect) : bus.pixel_in;
      bus.x_out     <= bus.x;
      bus.y_out     <= bus.y;
      bus.marker_on <= drawMarker;
    end
  end

endmodule
